// File: rtl/dvs_event_sequencer.sv
// -----------------------------------------------------------------------------
// dvs_event_sequencer
//
// Purpose:
//    Sits behind the DVS AER receiver. Each Y (row) word opens a row, and every
//    X (column + polarity) word that follows is paired with that row. The
//    resulting 20-bit events go into a first-word-fall-through FIFO that a
//    valid/ready consumer drains. X words that arrive with no open row are
//    dropped and counted. A row that sees no words for ROW_TIMEOUT cycles is
//    closed.
//
// Parameters:
//    FIFO_DEPTH   event FIFO entries (power of 2, >= 2)
//    ROW_TIMEOUT  idle cycles before an open row closes (0 = never)
//    CNT_WIDTH    width of drop_count
//
// Ports:
//    clk           system clock
//    rst_n         asynchronous active-low reset
//    enable        1 = accept words, 0 = ignore rx_valid and fall back to IDLE
//    rx_valid      one-cycle strobe qualifying aer_rx / xsel_rx
//    aer_rx        received AER word
//    xsel_rx       1 = X word {x[8:0], pol}, 0 = Y word y[9:0]
//    ev_valid      FIFO head valid
//    ev_ready      consumer takes the head when ev_valid & ev_ready
//    ev_data       head event {y[9:0], x[8:0], pol}
//    fifo_level    number of occupied FIFO entries
//    overflow      sticky flag: an event was lost to a full FIFO
//    drop_count    saturating count of orphan X words plus FIFO-full losses
//    clear_status  synchronous clear of overflow and drop_count
// -----------------------------------------------------------------------------
module dvs_event_sequencer #(
   parameter int FIFO_DEPTH  = 16,
   parameter int ROW_TIMEOUT = 64,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic                          rx_valid,
   input  logic [9:0]                    aer_rx,
   input  logic                          xsel_rx,
   output logic                          ev_valid,
   input  logic                          ev_ready,
   output logic [19:0]                   ev_data,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   output logic [CNT_WIDTH-1:0]          drop_count,
   input  logic                          clear_status
);

   localparam int AW = $clog2(FIFO_DEPTH);
   // A zero timeout still needs a one-bit timer so the declaration stays legal.
   localparam int TW = (ROW_TIMEOUT > 0) ? $clog2(ROW_TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] TIMER_LOAD = TW'(ROW_TIMEOUT);

   typedef enum logic {
      IDLE     = 1'b0,
      ROW_OPEN = 1'b1
   } state_t;

   state_t          state, state_nxt;
   logic [9:0]      row, row_nxt;
   logic [TW-1:0]   timer, timer_nxt;
   logic            push;
   logic            orphan;

   logic [19:0]     ram [FIFO_DEPTH];
   logic [AW:0]     wr_ptr, rd_ptr;
   logic            full;
   logic            pop;
   logic            write_en;
   logic            lost;

   // State, latched row and idle timer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         row   <= '0;
         timer <= '0;
      end else begin
         state <= state_nxt;
         row   <= row_nxt;
         timer <= timer_nxt;
      end
   end

   // Next-state logic. Any accepted word in ROW_OPEN reloads the timer. The
   // row closes on the idle cycle in which the timer would reach zero, so an
   // open row survives exactly ROW_TIMEOUT idle cycles.
   always_comb begin
      state_nxt = state;
      row_nxt   = row;
      timer_nxt = timer;
      push      = 1'b0;
      orphan    = 1'b0;
      case (state)
         IDLE: begin
            if (rx_valid && enable) begin
               if (!xsel_rx) begin
                  state_nxt = ROW_OPEN;
                  row_nxt   = aer_rx;
                  timer_nxt = TIMER_LOAD;
               end else begin
                  orphan = 1'b1;
               end
            end
         end
         ROW_OPEN: begin
            if (!enable) begin
               state_nxt = IDLE;
            end else if (rx_valid) begin
               timer_nxt = TIMER_LOAD;
               if (!xsel_rx) begin
                  row_nxt = aer_rx;
               end else begin
                  push = 1'b1;
               end
            end else if (ROW_TIMEOUT != 0) begin
               if (timer <= TW'(1)) begin
                  state_nxt = IDLE;
                  timer_nxt = '0;
               end else begin
                  timer_nxt = timer - TW'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // FIFO control. A push into a full FIFO is kept only if the head leaves in
   // the same cycle; the new entry then lands in the slot being vacated.
   assign ev_valid   = (wr_ptr != rd_ptr);
   assign fifo_level = wr_ptr - rd_ptr;
   assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop        = ev_valid && ev_ready;
   assign write_en   = push && (!full || pop);
   assign lost       = push && full && !pop;

   // The head is read straight from storage. It is gated to zero when the FIFO
   // is empty so stale entries never show after a reset.
   assign ev_data = ev_valid ? ram[rd_ptr[AW-1:0]] : '0;

   // Event storage. It has no reset; the pointers alone define which entries
   // are valid.
   always_ff @(posedge clk) begin
      if (write_en) begin
         ram[wr_ptr[AW-1:0]] <= {row, aer_rx};
      end
   end

   // Read and write pointers carry an extra MSB to tell full from empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (write_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Status. Only one word arrives per cycle, so an orphan drop and a FIFO-full
   // loss never coincide. A clear takes priority over an increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (clear_status) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         if (lost) begin
            overflow <= 1'b1;
         end
         if ((orphan || lost) && (drop_count != {CNT_WIDTH{1'b1}})) begin
            drop_count <= drop_count + 1'b1;
         end
      end
   end

endmodule
